// File: rtl/board_pkg.sv
// Shared constants, colour codes and FSM state type for the board drawing path.
package board_pkg;

  localparam int unsigned BOARD_X0        = 72;
  localparam int unsigned BOARD_Y0        = 32;
  localparam int unsigned BOARD_TILES     = 11;
  localparam int unsigned BOARD_TILE_PX   = 16;
  localparam int unsigned BOARD_NUM_BOMBS = 6;
  localparam int unsigned BOARD_COLOUR_W  = 3;

  localparam logic [2:0] COL_FLOOR   = 3'b010;
  localparam logic [2:0] COL_WALL    = 3'b111;
  localparam logic [2:0] COL_SOFT    = 3'b110;
  localparam logic [2:0] COL_POWERUP = 3'b101;
  localparam logic [2:0] COL_EXPL    = 3'b100;
  localparam logic [2:0] COL_BOMB    = 3'b000;
  localparam logic [2:0] COL_GRID    = 3'b011;

  localparam logic [3:0] TILE_FLOOR = 4'd0;
  localparam logic [3:0] TILE_WALL  = 4'd1;
  localparam logic [3:0] TILE_SOFT  = 4'd2;

  typedef enum logic [2:0] {
    StIdle,
    StTile,
    StTileFlush,
    StBombSel,
    StBombWait,
    StBombDraw,
    StDone
  } draw_state_e;

  // Explosion overrides whatever tile lies underneath.
  function automatic logic [2:0] tile_colour(input logic [3:0] tile_id, input logic explosion);
    logic [2:0] colour;
    if (explosion) begin
      colour = COL_EXPL;
    end else begin
      case (tile_id)
        TILE_FLOOR: colour = COL_FLOOR;
        TILE_WALL:  colour = COL_WALL;
        TILE_SOFT:  colour = COL_SOFT;
        default:    colour = COL_POWERUP;
      endcase
    end
    return colour;
  endfunction

endpackage

// File: rtl/bomb_sprite_rom.sv
// 16x16 bomb sprite mask: a filled disc of radius 8 centred on the sprite.
module bomb_sprite_rom (
  input  logic [3:0]  row,
  output logic [15:0] mask
);

  always_comb begin
    case (row)
      4'd0:    mask = 16'h07E0;
      4'd1:    mask = 16'h1FF8;
      4'd2:    mask = 16'h3FFC;
      4'd3:    mask = 16'h7FFE;
      4'd4:    mask = 16'h7FFE;
      4'd5:    mask = 16'hFFFF;
      4'd6:    mask = 16'hFFFF;
      4'd7:    mask = 16'hFFFF;
      4'd8:    mask = 16'hFFFF;
      4'd9:    mask = 16'hFFFF;
      4'd10:   mask = 16'hFFFF;
      4'd11:   mask = 16'h7FFE;
      4'd12:   mask = 16'h7FFE;
      4'd13:   mask = 16'h3FFC;
      4'd14:   mask = 16'h1FF8;
      default: mask = 16'h07E0;
    endcase
  end

endmodule

// File: rtl/board_draw_seq.sv
// Frame-draw sequencer: raster-paints the tile board, then overlays visible bomb sprites.
// Tile grid lines are drawn over floor when BOARD_DRAW_GRID_EN is defined.
module board_draw_seq
  import board_pkg::*;
#(
  parameter int unsigned X0        = BOARD_X0,
  parameter int unsigned Y0        = BOARD_Y0,
  parameter int unsigned TILES     = BOARD_TILES,
  parameter int unsigned TILE_PX   = BOARD_TILE_PX,
  parameter int unsigned NUM_BOMBS = BOARD_NUM_BOMBS,
  parameter int unsigned COLOUR_W  = BOARD_COLOUR_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [8:0]          X,
  output logic [7:0]          Y,
  output logic [2:0]          bomb_id,
  input  logic [3:0]          map_tile_id,
  input  logic                has_explosion,
  input  logic [17:0]         bomb_info,
  output logic [8:0]          vga_x,
  output logic [7:0]          vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                plot
);

  localparam logic [8:0] XStart   = 9'(X0);
  localparam logic [8:0] XLast    = 9'(X0 + TILES * TILE_PX - 1);
  localparam logic [7:0] YStart   = 8'(Y0);
  localparam logic [7:0] YLast    = 8'(Y0 + TILES * TILE_PX - 1);
  localparam logic [2:0] LastBomb = 3'(NUM_BOMBS - 1);

  draw_state_e state_q;
  logic        flush_q;

  // Tile pipeline stage between the sampled query response and the plot register.
  logic        s1_valid_q;
  logic [8:0]  s1_x_q;
  logic [7:0]  s1_y_q;
  logic [2:0]  s1_colour_q;

  logic [8:0]  bx_q;
  logic [7:0]  by_q;
  logic [7:0]  pix_q;

  logic [2:0]  sample_colour;
  logic [7:0]  pix_next;
  logic [3:0]  draw_px;
  logic [3:0]  draw_py;
  logic [15:0] row_mask;

`ifdef BOARD_DRAW_GRID_EN
  localparam int unsigned TileBits = $clog2(TILE_PX);
  logic [8:0] grid_dx;
  logic [7:0] grid_dy;
  assign grid_dx = X - XStart;
  assign grid_dy = Y - YStart;
`endif

  always_comb begin
    sample_colour = tile_colour(map_tile_id, has_explosion);
`ifdef BOARD_DRAW_GRID_EN
    if (sample_colour == COL_FLOOR &&
        (grid_dx[TileBits-1:0] == '0 || grid_dy[TileBits-1:0] == '0)) begin
      sample_colour = COL_GRID;
    end
`endif
  end

  // In BOMB_WAIT the first sprite pixel is prepared so the 256 plots land inside BOMB_DRAW.
  assign pix_next = pix_q + 8'd1;
  assign draw_px  = (state_q == StBombWait) ? 4'd0 : pix_next[3:0];
  assign draw_py  = (state_q == StBombWait) ? 4'd0 : pix_next[7:4];

  bomb_sprite_rom u_sprite_rom (
    .row  (draw_py),
    .mask (row_mask)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      flush_q     <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_x_q      <= '0;
      s1_y_q      <= '0;
      s1_colour_q <= '0;
      bx_q        <= '0;
      by_q        <= '0;
      pix_q       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      X           <= XStart;
      Y           <= YStart;
      bomb_id     <= '0;
      vga_x       <= '0;
      vga_y       <= '0;
      vga_colour  <= '0;
      plot        <= 1'b0;
    end else begin
      s1_valid_q  <= (state_q == StTile);
      s1_x_q      <= X;
      s1_y_q      <= Y;
      s1_colour_q <= sample_colour;

      case (state_q)
        StIdle: begin
          plot <= 1'b0;
          if (start) begin
            X       <= XStart;
            Y       <= YStart;
            busy    <= 1'b1;
            state_q <= StTile;
          end
        end

        StTile, StTileFlush: begin
          plot <= s1_valid_q;
          if (s1_valid_q) begin
            vga_x      <= s1_x_q;
            vga_y      <= s1_y_q;
            vga_colour <= COLOUR_W'(s1_colour_q);
          end
          if (state_q == StTile) begin
            if (X == XLast) begin
              if (Y == YLast) begin
                flush_q <= 1'b0;
                state_q <= StTileFlush;
              end else begin
                X <= XStart;
                Y <= Y + 8'd1;
              end
            end else begin
              X <= X + 9'd1;
            end
          end else begin
            flush_q <= 1'b1;
            if (flush_q) begin
              bomb_id <= '0;
              state_q <= StBombSel;
            end
          end
        end

        StBombSel: begin
          plot    <= 1'b0;
          state_q <= StBombWait;
        end

        StBombWait: begin
          if (bomb_info[0]) begin
            bx_q       <= bomb_info[9:1];
            by_q       <= bomb_info[17:10];
            pix_q      <= '0;
            vga_x      <= bomb_info[9:1];
            vga_y      <= bomb_info[17:10];
            vga_colour <= COLOUR_W'(COL_BOMB);
            plot       <= row_mask[draw_px];
            state_q    <= StBombDraw;
          end else if (bomb_id == LastBomb) begin
            done    <= 1'b1;
            state_q <= StDone;
          end else begin
            bomb_id <= bomb_id + 3'd1;
            state_q <= StBombSel;
          end
        end

        StBombDraw: begin
          if (pix_q == 8'hFF) begin
            plot <= 1'b0;
            if (bomb_id == LastBomb) begin
              done    <= 1'b1;
              state_q <= StDone;
            end else begin
              bomb_id <= bomb_id + 3'd1;
              state_q <= StBombSel;
            end
          end else begin
            pix_q <= pix_next;
            vga_x <= bx_q + {5'd0, draw_px};
            vga_y <= by_q + {4'd0, draw_py};
            plot  <= row_mask[draw_px];
          end
        end

        StDone: begin
          plot    <= 1'b0;
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= StIdle;
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_board_draw_seq.sv
// Randomised self-checking bench for board_draw_seq against a frame-level plot list model.
module tb_board_draw_seq;

  localparam int BX0     = 72;
  localparam int BY0     = 32;
  localparam int NTILE   = 11;
  localparam int TPX     = 16;
  localparam int BOARD   = NTILE * TPX;
  localparam int NB      = 6;
  localparam int NPIX    = BOARD * BOARD;

  localparam logic [2:0] C_FLOOR = 3'b010;
  localparam logic [2:0] C_WALL  = 3'b111;
  localparam logic [2:0] C_SOFT  = 3'b110;
  localparam logic [2:0] C_PU    = 3'b101;
  localparam logic [2:0] C_EXPL  = 3'b100;
  localparam logic [2:0] C_BOMB  = 3'b000;
  localparam logic [2:0] C_GRID  = 3'b011;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy;
  logic        done;
  logic [8:0]  X;
  logic [7:0]  Y;
  logic [2:0]  bomb_id;
  logic [3:0]  map_tile_id;
  logic        has_explosion;
  logic [17:0] bomb_info;
  logic [8:0]  vga_x;
  logic [7:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        plot;

  board_draw_seq dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .X             (X),
    .Y             (Y),
    .bomb_id       (bomb_id),
    .map_tile_id   (map_tile_id),
    .has_explosion (has_explosion),
    .bomb_info     (bomb_info),
    .vga_x         (vga_x),
    .vga_y         (vga_y),
    .vga_colour    (vga_colour),
    .plot          (plot)
  );

  always #10 clk = ~clk;

  logic [3:0]  tile_map [NTILE][NTILE];
  bit          expl_map [NTILE][NTILE];
  logic [17:0] bombs    [NB];
  logic [19:0] exp_q    [$];

  int checks = 0;
  int errors = 0;
  bit aborted = 0;

  // Combinational stand-in for the bomb/stage block.
  int tx, ty;
  always_comb begin
    tx = (int'(X) - BX0) / TPX;
    ty = (int'(Y) - BY0) / TPX;
    if (tx < 0) tx = 0;
    if (tx > NTILE - 1) tx = NTILE - 1;
    if (ty < 0) ty = 0;
    if (ty > NTILE - 1) ty = NTILE - 1;
    map_tile_id   = tile_map[ty][tx];
    has_explosion = expl_map[ty][tx];
    bomb_info     = (int'(bomb_id) < NB) ? bombs[bomb_id] : 18'd0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      if (errors >= 200 && !aborted) begin
        aborted = 1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    end
  endtask

  function automatic logic [2:0] ref_colour(input int px, input int py);
    int t;
    if (expl_map[py / TPX][px / TPX]) return C_EXPL;
    t = int'(tile_map[py / TPX][px / TPX]);
    if (t == 0) begin
`ifdef BOARD_DRAW_GRID_EN
      if (px % TPX == 0 || py % TPX == 0) return C_GRID;
`endif
      return C_FLOOR;
    end
    if (t == 1) return C_WALL;
    if (t == 2) return C_SOFT;
    return C_PU;
  endfunction

  function automatic bit in_disc(input int px, input int py);
    return ((2 * px - 15) * (2 * px - 15) + (2 * py - 15) * (2 * py - 15)) <= 256;
  endfunction

  // Builds the ordered plot list for one frame and returns the frame length in cycles.
  task automatic build_expected(output int len);
    int nvis, bx, by;
    exp_q.delete();
    for (int py = 0; py < BOARD; py++)
      for (int px = 0; px < BOARD; px++)
        exp_q.push_back({9'(BX0 + px), 8'(BY0 + py), ref_colour(px, py)});
    nvis = 0;
    for (int k = 0; k < NB; k++) begin
      if (bombs[k][0]) begin
        nvis++;
        bx = int'(bombs[k][9:1]);
        by = int'(bombs[k][17:10]);
        for (int py = 0; py < 16; py++)
          for (int px = 0; px < 16; px++)
            if (in_disc(px, py)) exp_q.push_back({9'(bx + px), 8'(by + py), C_BOMB});
      end
    end
    len = 1 + NPIX + 2 + 2 * NB + 1 + 256 * nvis;
  endtask

  // Caller is at a negedge; cycle 1 is the cycle in which start is high.
  task automatic run_frame(input bit pre_started, input int abort_at, input bit poke_starts);
    int cyc, len, plots, exp_plots, quiet;
    bit fin;
    logic [8:0] xh1, xh2;
    logic [7:0] yh1, yh2;
    build_expected(len);
    exp_plots = exp_q.size();
    if (!pre_started) start = 1'b1;
    cyc = 1;
    plots = 0;
    fin = 0;
    xh1 = X;
    yh1 = Y;
    xh2 = X;
    yh2 = Y;
    while (!fin) begin
      @(negedge clk);
      cyc++;
      if (cyc == 2) begin
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
      end
      if (poke_starts && (cyc == 700 || cyc == 20000)) start = 1'b1;
      if (poke_starts && (cyc == 701 || cyc == 20001)) start = 1'b0;
      if (cyc % 5000 == 0) check("busy_mid_frame", 32'(busy), 32'd1);
      if (plot) begin
        plots++;
        if (exp_q.size() == 0) check("extra_plot", 32'd1, 32'd0);
        else check("plot", 32'({vga_x, vga_y, vga_colour}), 32'(exp_q.pop_front()));
        if (plots <= NPIX) check("tile_latency", 32'({vga_x, vga_y}), 32'({xh2, yh2}));
      end
      xh2 = xh1;
      yh2 = yh1;
      xh1 = X;
      yh1 = Y;
      if (done) begin
        check("frame_len", 32'(cyc), 32'(len));
        check("plot_count", 32'(plots), 32'(exp_plots));
        fin = 1;
      end else if (abort_at != 0 && cyc == abort_at) begin
        reset = 1'b1;
        @(negedge clk);
        check("rst_plot", 32'(plot), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_x", 32'(X), 32'(BX0));
        check("rst_y", 32'(Y), 32'(BY0));
        check("rst_done", 32'(done), 32'd0);
        reset = 1'b0;
        quiet = 0;
        for (int i = 0; i < 200; i++) begin
          @(negedge clk);
          if (plot || done || busy) quiet++;
        end
        check("rst_quiet", 32'(quiet), 32'd0);
        fin = 1;
      end else if (cyc > len + 100) begin
        check("done_timeout", 32'(cyc), 32'(len));
        fin = 1;
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    for (int r = 0; r < NTILE; r++)
      for (int c = 0; c < NTILE; c++) begin
        tile_map[r][c] = 4'd0;
        expl_map[r][c] = 0;
      end
    for (int k = 0; k < NB; k++) bombs[k] = 18'd0;

    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_plot", 32'(plot), 32'd0);
    check("reset_x", 32'(X), 32'(BX0));
    check("reset_y", 32'(Y), 32'(BY0));
    check("reset_bomb_id", 32'(bomb_id), 32'd0);
    check("reset_vga", 32'({vga_x, vga_y, vga_colour}), 32'd0);
    reset = 1'b0;

    // Frame A: random board and bombs, plus the fixed wall/explosion/bomb cases.
    for (int r = 0; r < NTILE; r++)
      for (int c = 0; c < NTILE; c++) begin
        int sel;
        sel = int'($urandom_range(0, 9));
        if (sel < 5) tile_map[r][c] = 4'd0;
        else if (sel < 7) tile_map[r][c] = 4'd1;
        else if (sel == 7) tile_map[r][c] = 4'd2;
        else tile_map[r][c] = 4'($urandom_range(3, 15));
        expl_map[r][c] = ($urandom_range(0, 4) == 0);
      end
    tile_map[0][0] = 4'd1;
    expl_map[0][0] = 0;
    expl_map[5][5] = 1;
    for (int k = 0; k < NB; k++)
      bombs[k] = {8'($urandom_range(32, 192)), 9'($urandom_range(72, 232)),
                  1'($urandom_range(0, 1))};
    bombs[2] = {8'd48, 9'd88, 1'b1};
    run_frame(0, 0, 1);

    // Start on the done cycle is ignored; holding it into IDLE starts frame B.
    start = 1'b1;
    @(negedge clk);
    check("done_start_busy", 32'(busy), 32'd0);
    check("done_start_done", 32'(done), 32'd0);
    run_frame(1, 1000, 0);

    // Frame C: all floor, all bombs invisible.
    for (int r = 0; r < NTILE; r++)
      for (int c = 0; c < NTILE; c++) begin
        tile_map[r][c] = 4'd0;
        expl_map[r][c] = 0;
      end
    for (int k = 0; k < NB; k++) bombs[k] = 18'd0;
    run_frame(0, 0, 0);
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_plot", 32'(plot), 32'd0);

    if (!aborted) $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
